// File: rtl/zeroriscy_rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: LSU over EX with
// an EX starvation guard, a one-stage write-back register, and source-operand hazard detection.
module zeroriscy_rf_wb_arbiter #(
  parameter int RV32E        = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic [4:0]            ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  output logic                  ex_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [4:0]            lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_ready_o,
  output logic [4:0]            waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  input  logic [4:0]            raddr_a_i,
  input  logic [4:0]            raddr_b_i,
  output logic                  hazard_o,
  output logic                  addr_err_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [CNT_W-1:0]      r_ex_wait_cnt;
  logic                  r_wb_valid;
  logic [4:0]            r_wb_addr;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic w_force_ex;
  logic w_ex_grant;
  logic w_lsu_grant;
  logic w_wb_live;
  logic w_wb_oob;

  function automatic logic src_dep(
    input logic [4:0] src,
    input logic       wb_v,
    input logic [4:0] wb_a,
    input logic       lsu_v,
    input logic [4:0] lsu_a,
    input logic       ex_v,
    input logic [4:0] ex_a
  );
    return (src != 5'd0) &&
           ((wb_v && (src == wb_a)) || (lsu_v && (src == lsu_a)) || (ex_v && (src == ex_a)));
  endfunction

  assign w_force_ex  = (r_ex_wait_cnt == CNT_LIMIT);
  assign lsu_ready_o = !rst && !(w_force_ex && ex_valid_i);
  assign ex_ready_o  = !rst && (!lsu_valid_i || w_force_ex);
  assign w_lsu_grant = lsu_valid_i && lsu_ready_o;
  assign w_ex_grant  = ex_valid_i && ex_ready_o;

  // Reset gates the WB entry immediately so an in-flight write never lands during reset.
  assign w_wb_live  = r_wb_valid && !rst;
  assign w_wb_oob   = (RV32E != 0) && r_wb_addr[4];
  assign we_a_o     = w_wb_live && (r_wb_addr != 5'd0) && !w_wb_oob;
  assign addr_err_o = w_wb_live && w_wb_oob;
  assign waddr_a_o  = r_wb_addr;
  assign wdata_a_o  = r_wb_data;

  assign hazard_o =
    src_dep(raddr_a_i, w_wb_live, r_wb_addr, lsu_valid_i, lsu_waddr_i, ex_valid_i, ex_waddr_i) ||
    src_dep(raddr_b_i, w_wb_live, r_wb_addr, lsu_valid_i, lsu_waddr_i, ex_valid_i, ex_waddr_i);

  // EX starvation counter: counts consecutive blocked EX cycles, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_wait_cnt <= {CNT_W{1'b0}};
    end else if (ex_valid_i && !ex_ready_o) begin
      if (r_ex_wait_cnt != CNT_LIMIT) begin
        r_ex_wait_cnt <= r_ex_wait_cnt + CNT_ONE;
      end
    end else begin
      r_ex_wait_cnt <= {CNT_W{1'b0}};
    end
  end

  // Write-back register: valid reloads every cycle, address/data only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= 5'd0;
      r_wb_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_wb_valid <= w_lsu_grant || w_ex_grant;
      if (w_lsu_grant) begin
        r_wb_addr <= lsu_waddr_i;
        r_wb_data <= lsu_wdata_i;
      end else if (w_ex_grant) begin
        r_wb_addr <= ex_waddr_i;
        r_wb_data <= ex_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_rf_wb_arbiter.sv
// Randomized scoreboard bench: a grant/hazard predictor pushes expected WB contents,
// a monitor pops and checks them one cycle later on two configurations (RV32E = 0 and 1).
module tb_zeroriscy_rf_wb_arbiter;

  localparam int LIMIT = 4;
  localparam int NCYC  = 900;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_v, lsu_v;
  logic [4:0]  ex_a, lsu_a, ra, rb;
  logic [31:0] ex_d, lsu_d;

  logic        ex_rdy [2];
  logic        lsu_rdy [2];
  logic [4:0]  wa_o [2];
  logic [31:0] wd_o [2];
  logic        we_o [2];
  logic        hz_o [2];
  logic        err_o [2];

  always #5 clk = ~clk;

  zeroriscy_rf_wb_arbiter #(.RV32E(0), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) u_dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_v), .ex_waddr_i(ex_a), .ex_wdata_i(ex_d), .ex_ready_o(ex_rdy[0]),
    .lsu_valid_i(lsu_v), .lsu_waddr_i(lsu_a), .lsu_wdata_i(lsu_d), .lsu_ready_o(lsu_rdy[0]),
    .waddr_a_o(wa_o[0]), .wdata_a_o(wd_o[0]), .we_a_o(we_o[0]),
    .raddr_a_i(ra), .raddr_b_i(rb), .hazard_o(hz_o[0]), .addr_err_o(err_o[0])
  );

  zeroriscy_rf_wb_arbiter #(.RV32E(1), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) u_dut_e (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_v), .ex_waddr_i(ex_a), .ex_wdata_i(ex_d), .ex_ready_o(ex_rdy[1]),
    .lsu_valid_i(lsu_v), .lsu_waddr_i(lsu_a), .lsu_wdata_i(lsu_d), .lsu_ready_o(lsu_rdy[1]),
    .waddr_a_o(wa_o[1]), .wdata_a_o(wd_o[1]), .we_a_o(we_o[1]),
    .raddr_a_i(ra), .raddr_b_i(rb), .hazard_o(hz_o[1]), .addr_err_o(err_o[1])
  );

  typedef struct {
    bit          v;
    bit          in_rst;
    logic [4:0]  a;
    logic [31:0] d;
  } wb_exp_t;

  wb_exp_t q[$];
  int      n_tests = 0;
  int      n_fail  = 0;

  // Reference state: consecutive EX losses and what the WB stage should hold.
  int          m_losses = 0;
  bit          m_wb_v   = 1'b0;
  logic [4:0]  m_wb_a   = 5'd0;
  bit          ex_acc   = 1'b0;
  bit          lsu_acc  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit dep(input logic [4:0] src, input bit wv, input logic [4:0] wa);
    if (src == 5'd0) return 1'b0;
    if (wv && src == wa) return 1'b1;
    if (lsu_v && src == lsu_a) return 1'b1;
    if (ex_v && src == ex_a) return 1'b1;
    return 1'b0;
  endfunction

  // Predictor: decides the winner from the priority rules, checks handshakes and hazard.
  always @(negedge clk) begin
    int      win;   // 0 none, 1 EX, 2 LSU
    bit      hz;
    wb_exp_t e;
    win = 0;
    if (!rst) begin
      if (lsu_v && ex_v)  win = (m_losses >= LIMIT) ? 1 : 2;
      else if (lsu_v)     win = 2;
      else if (ex_v)      win = 1;
      else                win = 0;
    end
    hz = dep(ra, m_wb_v && !rst, m_wb_a) || dep(rb, m_wb_v && !rst, m_wb_a);
    for (int k = 0; k < 2; k++) begin
      if (ex_v)  chk($sformatf("ex_ready[%0d]", k),  64'(ex_rdy[k]),  64'(win == 1));
      if (lsu_v) chk($sformatf("lsu_ready[%0d]", k), 64'(lsu_rdy[k]), 64'(win == 2));
      if (rst) begin
        chk($sformatf("rst_ex_ready[%0d]", k),  64'(ex_rdy[k]),  64'd0);
        chk($sformatf("rst_lsu_ready[%0d]", k), 64'(lsu_rdy[k]), 64'd0);
      end
      chk($sformatf("hazard[%0d]", k), 64'(hz_o[k]), 64'(hz));
    end
    if (rst) m_losses = 0;
    else if (ex_v && win != 1) m_losses = (m_losses + 1 > LIMIT) ? LIMIT : m_losses + 1;
    else m_losses = 0;
    e.v = (win != 0);
    e.in_rst = rst;
    e.a = (win == 2) ? lsu_a : ex_a;
    e.d = (win == 2) ? lsu_d : ex_d;
    q.push_back(e);
    m_wb_v  = e.v;
    if (e.v) m_wb_a = e.a;
    if (rst) m_wb_a = 5'd0;
    ex_acc  = (win == 1);
    lsu_acc = (win == 2);
  end

  // Monitor: checks the register-file write port against the queued expectation.
  always @(posedge clk) begin
    wb_exp_t e;
    bit      exp_we, exp_err, lands, rv;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int k = 0; k < 2; k++) begin
        rv      = (k == 1);
        lands   = e.v && (e.a != 5'd0) && (!rv || e.a < 5'd16);
        exp_we  = lands && !rst;
        exp_err = e.v && rv && (e.a >= 5'd16) && !rst;
        chk($sformatf("we[%0d]", k),  64'(we_o[k]),  64'(exp_we));
        chk($sformatf("err[%0d]", k), 64'(err_o[k]), 64'(exp_err));
        if (e.in_rst) begin
          chk($sformatf("rst_waddr[%0d]", k), 64'(wa_o[k]), 64'd0);
          chk($sformatf("rst_wdata[%0d]", k), 64'(wd_o[k]), 64'd0);
        end else if (e.v) begin
          chk($sformatf("waddr[%0d]", k), 64'(wa_o[k]), 64'(e.a));
          chk($sformatf("wdata[%0d]", k), 64'(wd_o[k]), 64'(e.d));
        end
      end
    end
  end

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(7) == 0) return 5'd0;
    return 5'($urandom_range(31));
  endfunction

  function automatic logic [4:0] rnd_src();
    case ($urandom_range(5))
      0:       return ex_a;
      1:       return lsu_a;
      2:       return m_wb_a;
      3:       return 5'd0;
      default: return 5'($urandom_range(31));
    endcase
  endfunction

  // Stimulus: requesters hold until accepted, then maybe issue a new request.
  initial begin
    int p;
    rst = 1'b1; ex_v = 1'b0; lsu_v = 1'b0;
    ex_a = 5'd0; lsu_a = 5'd0; ex_d = 32'd0; lsu_d = 32'd0;
    ra = 5'd0; rb = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      p = (c < 40) ? 100 : (c < 450) ? 85 : 40;
      rst = ((c >= 300 && c < 302) || (c >= 620 && c < 623)) ? 1'b1 : 1'b0;
      if (ex_acc || !ex_v) begin
        ex_v = ($urandom_range(99) < p);
        ex_a = rnd_addr();
        ex_d = $urandom;
      end
      if (lsu_acc || !lsu_v) begin
        lsu_v = ($urandom_range(99) < p);
        lsu_a = rnd_addr();
        lsu_d = $urandom;
      end
      ra = rnd_src();
      rb = rnd_src();
    end
    @(posedge clk);
    #1 ex_v = 1'b0; lsu_v = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
